uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmit responder for the MIPS150 datapath. It sits behind the address decoder's UART strobes (`WEUART`, `REUART`, `UARTsel`) and accepts byte stores into a small TX FIFO. It serializes the bytes onto `SerialOut` as 8N1 frames, LSB first, and returns a status word on loads.

## Interface
- `CLOCK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate. `BIT_TICKS = CLOCK_FREQ/BAUD_RATE` (integer divide) clocks per bit.
- `FIFO_DEPTH`, 4: TX FIFO entries. Must be a power of 2, at least 2.
- `Clock`, in, 1: single system clock, rising edge.
- `Reset`, in, 1: asynchronous, active-low reset.
- `WEUART`, in, 1: store strobe, one cycle per access.
- `REUART`, in, 1: load strobe, one cycle per access.
- `UARTsel`, in, 1: register select. 0 = STATUS, 1 = DATA.
- `DataIn`, in, 8: store data (`rt[7:0]`).
- `DataOut`, out, 32: registered load data.
- `SerialOut`, out, 1: UART line, idle high.

## Operation
- **DATA store** (`WEUART & UARTsel`): push `DataIn` if the FIFO is not full. If the FIFO is full, drop the byte and set the sticky `ovf` bit.
- **Fullness rule:** fullness is evaluated before any same-cycle pop. A store to a full FIFO is dropped even when the serializer pops in that cycle.
- **Ignored stores:** STATUS stores (`WEUART & ~UARTsel`) are ignored.
- **STATUS load** (`REUART & ~UARTsel`): `DataOut <= {29'b0, ovf, tx_idle, tx_ready}`.
  - `tx_ready` = FIFO not full.
  - `tx_idle` = FIFO empty and serializer in IDLE.
  - The load clears `ovf`. If an overflow occurs in the same cycle, the set wins and the read returns the old value.
- **DATA load** (`REUART & UARTsel`): `DataOut <= {(32-log2(FIFO_DEPTH)-1)'b0, count}`, where `count` is the FIFO occupancy, 0..`FIFO_DEPTH`.
- **Strobe priority:** if `WEUART` and `REUART` are asserted together, both act. A load sees pre-store state.
- **Serializer FSM:** IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: `SerialOut`=1. If the FIFO is non-empty, pop into shift register `sh[7:0]`, clear the bit counter, go to START.
  - START: `SerialOut`=0 for `BIT_TICKS` clocks, then DATA.
  - DATA: `SerialOut=sh[0]`. Every `BIT_TICKS` clocks, shift right and increment the bit counter. After 8 bits, go to STOP.
  - STOP: `SerialOut`=1 for `BIT_TICKS` clocks, then IDLE.
- **Baud counter:** `log2(BIT_TICKS)`+1 bits wide. It reloads to 0 on every state change and on every bit boundary. It never free-runs in IDLE.
- **FIFO pointers:** `log2(FIFO_DEPTH)`+1 bits, wrapping modulo 2·`FIFO_DEPTH`.
  - Full = MSBs differ and the low bits are equal.
  - Empty = pointers equal.

## Timing
- **Reset values:** `DataOut`=0, `SerialOut`=1, FSM=IDLE, FIFO empty, `ovf`=0, counters=0.
- **Reset mid-frame:** the frame is abandoned and `SerialOut` returns high asynchronously.
- **Load latency:** `DataOut` updates on the clock edge after the strobe cycle and holds until the next load.
- **Store to line latency:** store at edge N makes data visible at N+1. IDLE pops at N+1, and `SerialOut` falls at the N+2 edge.
- **Frame length:** exactly 10·`BIT_TICKS` clocks from the falling start edge to the end of the stop bit.
- **Back-to-back frames:** IDLE is occupied for exactly 1 cycle between the end of STOP and the next START. Inter-frame gap = 1 clock beyond the stop bit.
- **Burst acceptance:** with the FIFO empty and the serializer idle, `FIFO_DEPTH`+1 consecutive stores are all accepted. The first byte pops one cycle after its store and frees a slot.

## Configuration
- `UART_TX_PARITY_EN`: when defined, a PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for `BIT_TICKS` clocks.
  - Frame becomes 11·`BIT_TICKS` clocks.
- When undefined: no PARITY state and no parity logic. The frame is 8N1, 10·`BIT_TICKS` clocks.

## Test plan
All scenarios use `CLOCK_FREQ`=1000, `BAUD_RATE`=100 (`BIT_TICKS`=10), `FIFO_DEPTH`=4.
1. **Reset:** assert `Reset`=0 mid-frame -> `SerialOut`=1 immediately. After release, a STATUS load returns `0x00000003`.
2. **Single byte:** store 0xA5 -> `SerialOut` falls 2 edges later, then carries 0 for 10 clocks, bits 1,0,1,0,0,1,0,1 at 10 clocks each, then 1. Total 100 clocks. With `UART_TX_PARITY_EN`, a 0 parity bit is inserted and the total is 110 clocks.
3. **Overflow:** 6 consecutive stores 0x01..0x06 -> 0x01..0x05 are transmitted back-to-back with 1-clock gaps and 0x06 is lost. A STATUS load during the burst returns `0x00000004`. A second STATUS load returns `ovf`=0.
4. **Occupancy:** 3 stores, then a DATA load on the following cycle -> `DataOut`=2, since one byte has already been popped.
5. **Simultaneous events:** a store to a full FIFO in the same cycle the serializer pops -> the byte is dropped and `ovf`=1. A STATUS load in the same cycle as the overflow returns the old `ovf`=0, and `ovf` reads 1 on the next load.
6. **Idle flag:** after the last stop bit, `tx_idle` reads 1. A store followed by a STATUS load on the next cycle returns `tx_idle`=0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter, TX FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_mmio #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        WEUART,
    input  logic        REUART,
    input  logic        UARTsel,
    input  logic [7:0]  DataIn,
    output logic [31:0] DataOut,
    output logic        SerialOut
);

    localparam int BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BIT_TICKS) + 1;
    localparam logic [CW-1:0] LAST_TICK = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t state_q;
    state_t state_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          ovf_q;
    logic          st_rd;
    logic          dt_rd;
    logic          tx_idle;

    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          tick;
    logic          bit_last;
    logic          ser_d;
    logic          ser_q;
`ifdef UART_TX_PARITY_EN
    logic          par_q;
`endif

    // Occupancy wraps modulo 2*FIFO_DEPTH, so full and empty stay distinct.
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign count = wptr_q - rptr_q;

    assign push    = WEUART & UARTsel & ~full;
    assign ovf_set = WEUART & UARTsel & full;
    assign st_rd   = REUART & ~UARTsel;
    assign dt_rd   = REUART & UARTsel;
    assign tx_idle = empty && (state_q == S_IDLE);

    assign tick     = (cnt_q == LAST_TICK);
    assign bit_last = (bit_q == 3'd7);

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= DataIn;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // A same-cycle overflow beats the clear-on-read.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (st_rd) begin
            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            DataOut <= '0;
        end else if (st_rd) begin
            DataOut <= {29'b0, ovf_q, tx_idle, ~full};
        end else if (dt_rd) begin
            DataOut <= {{(31-AW){1'b0}}, count};
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_START;
            end
            S_START: begin
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (tick && bit_last) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ser_d = 1'b1;
        pop   = 1'b0;
        case (state_q)
            S_IDLE:   pop   = !empty;
            S_START:  ser_d = 1'b0;
            S_DATA:   ser_d = sh_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: ser_d = par_q;
`endif
            default:  ser_d = 1'b1;
        endcase
    end

    // Line is registered, so it trails the FSM state by one clock.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ser_q <= 1'b1;
        end else begin
            ser_q <= ser_d;
        end
    end

    assign SerialOut = ser_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if ((state_d != state_q) || tick) begin
            cnt_q <= '0;
        end else if (state_q != S_IDLE) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sh_q  <= '0;
            bit_q <= '0;
        end else if (pop) begin
            sh_q  <= mem[rptr_q[AW-1:0]];
            bit_q <= '0;
        end else if ((state_q == S_DATA) && tick) begin
            sh_q  <= {1'b0, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            par_q <= 1'b0;
        end else if (pop) begin
            par_q <= ^mem[rptr_q[AW-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: random and directed MMIO traffic against a queue-based
// transaction model; monitors decode the line and check load data.
module tb_uart_tx_mmio;

    localparam int BT    = 10;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FB = NB * BT;

    logic        Clock;
    logic        Reset;
    logic        WEUART;
    logic        REUART;
    logic        UARTsel;
    logic [7:0]  DataIn;
    logic [31:0] DataOut;
    logic        SerialOut;

    uart_tx_mmio #(
        .CLOCK_FREQ(1000),
        .BAUD_RATE (100),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .WEUART   (WEUART),
        .REUART   (REUART),
        .UARTsel  (UARTsel),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .SerialOut(SerialOut)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int edge_n = 0;
    always @(posedge Clock) edge_n <= edge_n + 1;

    typedef struct {
        logic [7:0] b;
        int         fall;
    } frame_t;

    typedef struct {
        logic [31:0] v;
        int          e;
    } ld_t;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] mq[$];
    frame_t     txq[$];
    ld_t        ldq[$];
    int         free_at = 0;
    bit         movf = 0;
    bit         infr = 0;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        txq.delete();
        ldq.delete();
        free_at = 0;
        movf = 0;
    endtask

    // Serializer is idle in cycle k iff k >= free_at; a pop at edge k
    // occupies the next FB cycles and the line falls at edge k+1.
    task automatic model_step(input logic we, input logic re,
                              input logic sel, input logic [7:0] d);
        int     k;
        int     n;
        bit     full;
        bit     idle;
        bit     canpop;
        ld_t    l;
        frame_t f;
        k      = edge_n;
        n      = mq.size();
        full   = (n == DEPTH);
        idle   = (k >= free_at) && (n == 0);
        canpop = (k >= free_at) && (n > 0);
        if (re) begin
            l.e = k;
            if (sel) l.v = n;
            else     l.v = {29'b0, movf, idle, !full};
            ldq.push_back(l);
            if (!sel) movf = 0;
        end
        if (we && sel) begin
            if (full) movf = 1;
            else      mq.push_back(d);
        end
        if (canpop) begin
            f.b    = mq.pop_front();
            f.fall = k + 1;
            txq.push_back(f);
            free_at = k + FB + 1;
        end
    endtask

    task automatic cyc(input logic we, input logic re, input logic sel,
                       input logic [7:0] d);
        WEUART  = we;
        REUART  = re;
        UARTsel = sel;
        DataIn  = d;
        @(posedge Clock);
        model_step(we, re, sel, d);
        #1;
        WEUART = 1'b0;
        REUART = 1'b0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00);
    endtask

    // Load checker: DataOut is compared one clock after the strobe.
    initial begin : load_mon
        ld_t l;
        forever begin
            @(posedge Clock);
            #1;
            if (ldq.size() > 0 && ldq[0].e == edge_n - 1) begin
                l = ldq.pop_front();
                chk("load", DataOut, l.v);
            end
        end
    end

    // Line checker: every clock of each frame is compared to the
    // expected start/data/parity/stop bit pattern.
    initial begin : line_mon
        frame_t      f;
        logic [10:0] fb;
        int          t;
        int          j;
        bit          bad;
        t   = 0;
        bad = 0;
        fb  = '1;
        forever begin
            @(posedge Clock);
            #1;
            j = edge_n - 1;
            if (!Reset) begin
                infr = 0;
            end else begin
                if (!infr && SerialOut == 1'b0) begin
                    if (txq.size() == 0) begin
                        chk("unexpected_start", 32'(j), 32'hFFFF_FFFF);
                    end else begin
                        f = txq.pop_front();
                        chk("start_edge", 32'(j), 32'(f.fall));
                        fb     = '1;
                        fb[0]  = 1'b0;
                        fb[8:1] = f.b;
`ifdef UART_TX_PARITY_EN
                        fb[9]  = ^f.b;
`endif
                        infr = 1;
                        t    = 0;
                        bad  = 0;
                    end
                end
                if (infr) begin
                    if (SerialOut !== fb[t / BT]) bad = 1;
                    t++;
                    if (t == FB) begin
                        vectors++;
                        if (bad) begin
                            errors++;
                            $display("FAIL frame: byte %h line pattern wrong",
                                     f.b);
                        end
                        infr = 0;
                    end
                end
            end
        end
    end

    initial begin : stim
        bit found;
        Reset   = 1'b1;
        WEUART  = 1'b0;
        REUART  = 1'b0;
        UARTsel = 1'b0;
        DataIn  = 8'h00;
        #1 Reset = 1'b0;
        #1;
        chk("reset_line", 32'(SerialOut), 32'd1);
        chk("reset_dout", DataOut, 32'd0);
        repeat (2) @(posedge Clock);
        #5 Reset = 1'b1;
        model_reset();

        cyc(0, 1, 0, 8'h00);
        idle_n(2);

        cyc(1, 0, 1, 8'hA5);
        idle_n(FB + 10);

        cyc(0, 1, 0, 8'h00);
        cyc(1, 0, 1, 8'h3C);
        cyc(0, 1, 0, 8'h00);
        idle_n(FB + 5);

        for (int i = 1; i <= 5; i++) cyc(1, 0, 1, 8'(i));
        cyc(0, 1, 0, 8'h00);
        cyc(1, 0, 1, 8'h06);
        cyc(0, 1, 0, 8'h00);
        cyc(0, 1, 0, 8'h00);
        idle_n(6 * (FB + 1));

        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'h70 + 8'(i));
        cyc(0, 1, 1, 8'h00);
        idle_n(4 * (FB + 1));

        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 8'h90 + 8'(i));
        found = 0;
        for (int i = 0; i < 3 * FB && !found; i++) begin
            if (edge_n >= free_at && mq.size() == DEPTH) begin
                cyc(1, 1, 1, 8'hEE);
                cyc(0, 1, 0, 8'h00);
                cyc(0, 1, 0, 8'h00);
                found = 1;
            end else begin
                cyc(0, 0, 0, 8'h00);
            end
        end
        chk("pop_full_found", 32'(found), 32'd1);
        idle_n(6 * (FB + 1));

        cyc(1, 0, 1, 8'h00);
        idle_n(4 * BT);
        #2 Reset = 1'b0;
        #1;
        chk("async_line", 32'(SerialOut), 32'd1);
        chk("async_dout", DataOut, 32'd0);
        repeat (3) @(posedge Clock);
        #5 Reset = 1'b1;
        model_reset();
        cyc(0, 1, 0, 8'h00);
        idle_n(2);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), 8'($urandom));
        end
        idle_n(6 * (FB + 1));
        cyc(0, 1, 0, 8'h00);
        idle_n(3);

        chk("frames_left", 32'(txq.size()), 32'd0);
        chk("loads_left", 32'(ldq.size()), 32'd0);
        chk("mid_frame", 32'(infr), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
